// File: rtl/wb_reg_file.sv
// Write-back register file for the 8-bit MIPS datapath.
// It has two combinational read ports with write-first bypass.
// A per-register busy scoreboard lets decode stall on RAW hazards.
// r0 is hardwired to zero and can never be reserved.
module wb_reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              sb_any
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  sb;

  // A commit is visible to readers in the same cycle through the bypass.
  logic hit1;
  logic hit2;

  assign hit1 = we && (wa == ra1);
  assign hit2 = we && (wa == ra2);

  // Register storage: commit the write-back data on the rising edge.
  // NOTE: the array is reset on purpose. After reset every read must return 0,
  // so these flops cannot be left as an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      // NOTE: use non-blocking assignments for all sequential state.
      // Blocking assignments here would race against readers on the same edge.
      regs[wa] <= wd;
    end
  end

  // Scoreboard: a reservation sets a bit and a commit clears it.
  // A set wins over a clear because the newer instruction owns the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      sb[0] <= 1'b0;
      for (int i = 1; i < NREGS; i++) begin
        if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
          sb[i] <= 1'b1;
        end else if (we && (wa == ADDR_W'(i))) begin
          sb[i] <= 1'b0;
        end
      end
    end
  end

  // Read ports: r0 reads as zero, then the bypass, then the stored value.
  always_comb begin
    // NOTE: give every output a default first so no path can infer a latch.
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) begin
      rd1 = hit1 ? wd : regs[ra1];
    end
    if (ra2 != '0) begin
      rd2 = hit2 ? wd : regs[ra2];
    end
  end

  // Hazard flags: a commit in this cycle satisfies the hazard, so no stall.
  always_comb begin
    busy1 = (ra1 != '0) && sb[ra1] && !hit1;
    busy2 = (ra2 != '0) && sb[ra2] && !hit2;
  end

  // Drain/debug flag: based on registered state only, with no bypass term.
  assign sb_any = |sb;

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Write-back register file for the 8-bit MIPS datapath. It sits directly downstream of the write-back select mux and consumes that mux's 8-bit output as its write data.
- Provides two combinational read ports with write-first bypass to the decode stage.
- Holds a per-register busy scoreboard. Decode reserves a destination when it issues an instruction; the reservation clears when write-back commits. Decode uses the busy flags to stall on RAW hazards.

Parameters:
DATA_W, 8, register and data width in bits
ADDR_W, 3, register address width; NREGS = 2**ADDR_W registers (r0..r7)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active-low
ra1  input  ADDR_W  read address, port 1 (rs)
ra2  input  ADDR_W  read address, port 2 (rt)
rd1  output  DATA_W  read data, port 1
rd2  output  DATA_W  read data, port 2
we  input  1  write-back commit strobe
wa  input  ADDR_W  write-back destination register
wd  input  DATA_W  write-back data (output of the write-back select mux)
rsv_en  input  1  reserve the destination at issue
rsv_addr  input  ADDR_W  destination being reserved
busy1  output  1  ra1 has a pending write not yet committed
busy2  output  1  ra2 has a pending write not yet committed
sb_any  output  1  OR of all scoreboard bits; used for pipeline drain and debug

Behaviour:
- Storage: NREGS x DATA_W flops plus an NREGS-bit scoreboard sb.
- Reset (rst_n low, asynchronous, no clock needed):
  - all registers = 0, sb = 0.
  - Consequently rd1 = rd2 = 0 for every address, busy1 = busy2 = 0, sb_any = 0.
  - Reset asserted mid-operation discards any pending write and all reservations immediately.
- r0:
  - reads always return 0.
  - writes and reservations to r0 are ignored.
  - sb[0] is constant 0.
- Write: on the rising edge, if we and wa != 0, then reg[wa] <= wd.
- Read (combinational, zero latency):
  - rdN = 0 if raN == 0.
  - else rdN = wd if (we and wa == raN), which is the write-first bypass.
  - else rdN = reg[raN].
  - Both ports may read the same register; both bypass independently.
- Scoreboard, per register i != 0, at the rising edge:
  - set = rsv_en and rsv_addr == i.
  - clr = we and wa == i.
  - sb[i] <= set ? 1 : (clr ? 0 : sb[i]).
  - Set beats clear on the same register in the same cycle: the newer instruction owns the register.
- busy flags (combinational):
  - busyN = sb[raN] and not (we and wa == raN) and raN != 0.
  - A commit in the current cycle satisfies the hazard through the bypass, so no stall is raised.
  - A same-cycle reservation does not affect busyN until the next cycle.
- Write with sb[wa] already 0 (no prior reservation) is legal: data is written and the scoreboard is unchanged.
- Double reservation of the same register is legal: the bit stays 1 and the first commit clears it. Keeping issue in order is the pipeline's responsibility.
- sb_any = |sb, registered-state based; it does not include a same-cycle bypass.
- No X propagation: every address value 0..NREGS-1 is valid, so there are no out-of-range cases.

Test Plan:
- Reset then read: pulse rst_n low; ra1=3, ra2=7 -> rd1=0, rd2=0, busy1=busy2=0, sb_any=0.
- Write/readback: we=1, wa=5, wd=0xA7 for one edge; next cycle ra1=5 -> rd1=0xA7. Write wa=0, wd=0xFF; ra2=0 -> rd2=0.
- Bypass: reg4 holds 0x11; in the same cycle we=1, wa=4, wd=0x3C, ra1=ra2=4 -> rd1=rd2=0x3C combinationally; after the edge, reg4=0x3C.
- Hazard: rsv_en=1, rsv_addr=2 at an edge; next cycle ra1=2 -> busy1=1, sb_any=1. Commit we=1, wa=2, wd=0x55 -> busy1=0 in that cycle and rd1=0x55; after the edge sb[2]=0 and sb_any=0.
- Set-beats-clear: sb[6]=1; in the same edge we=1, wa=6 and rsv_en=1, rsv_addr=6 -> after the edge sb[6]=1 and reg6 is updated.
- Async reset mid-op: sb[1]=sb[3]=1 and reg3=0x9E; drop rst_n between edges -> busy flags and sb_any fall immediately, and rd1 for ra1=3 reads 0 without a clock edge.
